// File: rtl/food_spawner_if.sv
// food_spawner_if: head/eat/plot signals between snake logic, food spawner and plot arbiter.
interface food_spawner_if #(
  parameter int NUM_FOOD = 4,
  parameter int X_W      = 8,
  parameter int Y_W      = 7
);
  logic [X_W-1:0]      head_x;
  logic [Y_W-1:0]      head_y;
  logic                head_valid;
  logic                eaten;
  logic [2:0]          eaten_idx;
  logic                plot_req;
  logic [X_W-1:0]      plot_x;
  logic [Y_W-1:0]      plot_y;
  logic                plot_ack;
  logic [NUM_FOOD-1:0] food_live;
  logic                busy;
  modport master (
    input  head_x, head_y, head_valid, plot_ack,
    output eaten, eaten_idx, plot_req, plot_x, plot_y, food_live, busy
  );
  modport slave (
    output head_x, head_y, head_valid, plot_ack,
    input  eaten, eaten_idx, plot_req, plot_x, plot_y, food_live, busy
  );
endinterface

// File: rtl/food_spawner.sv
// food_spawner: keeps NUM_FOOD food items alive at LFSR-random positions clear of the head
// and of each other, reports eats and requests one-pixel plots for new items.
module food_spawner #(
  parameter int NUM_FOOD = 4,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119,
  parameter int LFSR_W   = 16,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input logic clk_i,
  input logic rst_i,
  food_spawner_if.master bus
);
  localparam int IW = NUM_FOOD > 1 ? $clog2(NUM_FOOD) : 1;
  localparam logic [2:0] FILL_SCAN = 3'd0, GEN = 3'd1, CHECK = 3'd2, PLOT = 3'd3, IDLE = 3'd4;
  localparam logic [63:0] TAP_TAB = LFSR_W == 4  ? 64'hC :
                                    LFSR_W == 8  ? 64'hB8 :
                                    LFSR_W == 15 ? 64'h6000 :
                                    LFSR_W == 16 ? 64'hB400 :
                                    LFSR_W == 24 ? 64'hE10000 : (64'hB400 << LFSR_W) >> 16;
  localparam logic [LFSR_W-1:0] TAPS  = TAP_TAB[LFSR_W-1:0];
  localparam logic [LFSR_W-1:0] SEED0 = SEED == '0 ? LFSR_W'(1) : SEED;
  localparam logic [X_W-1:0]    XM    = X_W'(X_MAX);
  localparam logic [Y_W-1:0]    YM    = Y_W'(Y_MAX);

  logic [2:0]          state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [IW-1:0]       slot_q, slot_d;
  logic [X_W-1:0]      cand_x_q, cand_x_d, pend_x_q, pend_x_d, plot_x_q, plot_x_d;
  logic [Y_W-1:0]      cand_y_q, cand_y_d, pend_y_q, pend_y_d, plot_y_q, plot_y_d;
  logic [X_W-1:0]      fx_q [NUM_FOOD];
  logic [X_W-1:0]      fx_d [NUM_FOOD];
  logic [Y_W-1:0]      fy_q [NUM_FOOD];
  logic [Y_W-1:0]      fy_d [NUM_FOOD];
  logic [NUM_FOOD-1:0] live_q, live_d;
  logic                eaten_q, eaten_d, plot_req_q, plot_req_d, pend_q, pend_d;
  logic [2:0]          eidx_q, eidx_d;
  logic                free_any, hit_any, cand_hit, reject;
  logic [IW-1:0]       free_idx, hit_idx;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    hit_any  = 1'b0;
    hit_idx  = '0;
    cand_hit = 1'b0;
    for (int i = NUM_FOOD - 1; i >= 0; i--) begin
      if (!live_q[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
      if (live_q[i] && fx_q[i] == pend_x_q && fy_q[i] == pend_y_q) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
      if (live_q[i] && fx_q[i] == cand_x_q && fy_q[i] == cand_y_q) cand_hit = 1'b1;
    end
  end

  assign reject = cand_x_q > XM || cand_y_q > YM || cand_hit ||
                  (cand_x_q == bus.head_x && cand_y_q == bus.head_y);

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q[0] ? (lfsr_q >> 1) ^ TAPS : lfsr_q >> 1;
    slot_d     = slot_q;
    cand_x_d   = cand_x_q;
    cand_y_d   = cand_y_q;
    fx_d       = fx_q;
    fy_d       = fy_q;
    live_d     = live_q;
    eaten_d    = 1'b0;
    eidx_d     = eidx_q;
    plot_req_d = plot_req_q;
    plot_x_d   = plot_x_q;
    plot_y_d   = plot_y_q;
    // Every move lands in the pending slot; IDLE consumes it one cycle later.
    pend_d     = bus.head_valid ? 1'b1 : (state_q == IDLE ? 1'b0 : pend_q);
    pend_x_d   = bus.head_valid ? bus.head_x : pend_x_q;
    pend_y_d   = bus.head_valid ? bus.head_y : pend_y_q;
    case (state_q)
      FILL_SCAN: begin
        slot_d  = free_idx;
        state_d = free_any ? GEN : IDLE;
      end
      GEN: begin
        cand_x_d = lfsr_q[X_W-1:0];
        cand_y_d = lfsr_q[X_W+Y_W-1:X_W];
        state_d  = CHECK;
      end
      CHECK: begin
        state_d = reject ? GEN : PLOT;
        if (!reject) begin
          fx_d[slot_q]   = cand_x_q;
          fy_d[slot_q]   = cand_y_q;
          live_d[slot_q] = 1'b1;
          plot_req_d     = 1'b1;
          plot_x_d       = cand_x_q;
          plot_y_d       = cand_y_q;
        end
      end
      PLOT: begin
        plot_req_d = bus.plot_ack ? 1'b0 : plot_req_q;
        state_d    = bus.plot_ack ? FILL_SCAN : PLOT;
      end
      IDLE: begin
        if (pend_q && hit_any) begin
          eaten_d         = 1'b1;
          eidx_d          = 3'(hit_idx);
          live_d[hit_idx] = 1'b0;
          state_d         = FILL_SCAN;
        end
      end
      default: state_d = FILL_SCAN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= FILL_SCAN;
      lfsr_q     <= SEED0;
      slot_q     <= '0;
      cand_x_q   <= '0;
      cand_y_q   <= '0;
      for (int i = 0; i < NUM_FOOD; i++) begin
        fx_q[i] <= '0;
        fy_q[i] <= '0;
      end
      live_q     <= '0;
      eaten_q    <= 1'b0;
      eidx_q     <= '0;
      plot_req_q <= 1'b0;
      plot_x_q   <= '0;
      plot_y_q   <= '0;
      pend_q     <= 1'b0;
      pend_x_q   <= '0;
      pend_y_q   <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      slot_q     <= slot_d;
      cand_x_q   <= cand_x_d;
      cand_y_q   <= cand_y_d;
      fx_q       <= fx_d;
      fy_q       <= fy_d;
      live_q     <= live_d;
      eaten_q    <= eaten_d;
      eidx_q     <= eidx_d;
      plot_req_q <= plot_req_d;
      plot_x_q   <= plot_x_d;
      plot_y_q   <= plot_y_d;
      pend_q     <= pend_d;
      pend_x_q   <= pend_x_d;
      pend_y_q   <= pend_y_d;
    end
  end

  assign bus.eaten     = eaten_q;
  assign bus.eaten_idx = eidx_q;
  assign bus.plot_req  = plot_req_q;
  assign bus.plot_x    = plot_x_q;
  assign bus.plot_y    = plot_y_q;
  assign bus.food_live = live_q;
  assign bus.busy      = state_q != IDLE;
endmodule

// File: tb/tb_food_spawner.sv
// tb_food_spawner: directed checks of fill, eat, plot hold, pending moves and reset,
// plus a tiny 4x4 instance checking food never spawns under the head.
module tb_food_spawner;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  food_spawner_if #(.NUM_FOOD(4), .X_W(8), .Y_W(7)) bus ();
  food_spawner dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  food_spawner_if #(.NUM_FOOD(1), .X_W(2), .Y_W(2)) sbus ();
  food_spawner #(.NUM_FOOD(1), .X_W(2), .Y_W(2), .X_MAX(3), .Y_MAX(3), .LFSR_W(4),
                 .SEED(4'h9)) sdut (.clk_i(clk), .rst_i(rst), .bus(sbus));

  int tests = 0;
  int fails = 0;
  logic [7:0] ex [4];
  logic [6:0] ey [4];
  logic [7:0] cx [4];
  logic [6:0] cy [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] v);
    return v[0] ? (v >> 1) ^ 16'hB400 : v >> 1;
  endfunction

  task automatic wait_plot(output logic [7:0] x, output logic [6:0] y);
    int n = 0;
    while (!bus.plot_req && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("plot_timeout", 32'(n < 500), 32'd1);
    x = bus.plot_x;
    y = bus.plot_y;
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(n < 500), 32'd1);
  endtask

  task automatic fill_check(input string tag);
    logic [7:0] x;
    logic [6:0] y;
    for (int i = 0; i < 4; i++) begin
      wait_plot(x, y);
      check({tag, "_x"}, 32'(x), 32'(ex[i]));
      check({tag, "_y"}, 32'(y), 32'(ey[i]));
      cx[i] = x;
      cy[i] = y;
    end
    check({tag, "_first_x"}, 32'(cx[0]), 32'd112);
    check({tag, "_first_y"}, 32'(cy[0]), 32'd98);
    repeat (2) @(negedge clk);
    check({tag, "_live"}, 32'(bus.food_live), 32'hF);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic pulse(input logic [7:0] x, input logic [6:0] y);
    bus.head_x = x;
    bus.head_y = y;
    bus.head_valid = 1'b1;
    @(negedge clk);
    bus.head_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    logic [7:0] x, hx;
    logic [6:0] y, hy;
    logic bad;
    int s, n, chg, nplots;
    // Reference fill: head at (0,0), immediate ack; reject costs 2 LFSR steps, accept 4.
    v = step(16'hACE1);
    s = 0;
    while (s < 4) begin
      x = v[7:0];
      y = v[14:8];
      bad = x > 8'd159 || y > 7'd119 || (x == 8'd0 && y == 7'd0);
      for (int j = 0; j < s; j++) if (ex[j] == x && ey[j] == y) bad = 1'b1;
      if (bad) v = step(step(v));
      else begin
        ex[s] = x;
        ey[s] = y;
        s++;
        v = step(step(step(step(v))));
      end
    end
    bus.head_x = '0; bus.head_y = '0; bus.head_valid = 1'b0; bus.plot_ack = 1'b1;
    sbus.head_x = 2'd2; sbus.head_y = 2'd2; sbus.head_valid = 1'b0; sbus.plot_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_eaten", 32'(bus.eaten), 32'd0);
    check("rst_idx", 32'(bus.eaten_idx), 32'd0);
    check("rst_req", 32'(bus.plot_req), 32'd0);
    check("rst_px", 32'(bus.plot_x), 32'd0);
    check("rst_py", 32'(bus.plot_y), 32'd0);
    check("rst_live", 32'(bus.food_live), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b0;
    fill_check("fill");

    // Eat slot 2 while the plotter stalls the refill.
    bus.plot_ack = 1'b0;
    pulse(cx[2], cy[2]);
    @(negedge clk);
    check("eat_pulse", 32'(bus.eaten), 32'd1);
    check("eat_idx", 32'(bus.eaten_idx), 32'd2);
    check("eat_live", 32'(bus.food_live), 32'hB);
    @(negedge clk);
    check("eat_once", 32'(bus.eaten), 32'd0);
    wait_plot(hx, hy);
    check("regen_head", 32'(hx == cx[2] && hy == cy[2]), 32'd0);
    check("regen_s0", 32'(hx == cx[0] && hy == cy[0]), 32'd0);
    check("regen_s1", 32'(hx == cx[1] && hy == cy[1]), 32'd0);
    check("regen_s3", 32'(hx == cx[3] && hy == cy[3]), 32'd0);
    check("regen_range", 32'(hx <= 8'd159 && hy <= 7'd119), 32'd1);
    chg = 0;
    repeat (50) begin
      @(negedge clk);
      if (!bus.plot_req || bus.plot_x != hx || bus.plot_y != hy) chg++;
    end
    check("hold", 32'(chg), 32'd0);
    bus.plot_ack = 1'b1;
    @(negedge clk);
    check("ack_drop", 32'(bus.plot_req), 32'd0);
    cx[2] = hx;
    cy[2] = hy;
    wait_idle();
    check("regen_live", 32'(bus.food_live), 32'hF);

    // Two moves while busy: only the later (slot 3) is evaluated in IDLE.
    bus.plot_ack = 1'b0;
    pulse(cx[0], cy[0]);
    wait_plot(hx, hy);
    pulse(cx[1], cy[1]);
    repeat (3) @(negedge clk);
    pulse(cx[3], cy[3]);
    repeat (3) @(negedge clk);
    bus.plot_ack = 1'b1;
    n = 0;
    while (!bus.eaten && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("pend_seen", 32'(n < 200), 32'd1);
    check("pend_idx", 32'(bus.eaten_idx), 32'd3);
    check("pend_live", 32'(bus.food_live), 32'h7);
    wait_idle();

    // Reset in the middle of a plot.
    bus.plot_ack = 1'b0;
    pulse(cx[1], cy[1]);
    bus.head_x = '0;
    bus.head_y = '0;
    wait_plot(hx, hy);
    rst = 1'b1;
    @(negedge clk);
    check("rstplot_req", 32'(bus.plot_req), 32'd0);
    check("rstplot_live", 32'(bus.food_live), 32'd0);
    check("rstplot_busy", 32'(bus.busy), 32'd1);
    bus.plot_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fill_check("refill");

    // Small field: food must never appear under the head at (2,2).
    for (int k = 0; k < 200; k++) begin
      n = 0;
      while ((sbus.busy || sbus.food_live != 1'b1) && n < 200) begin
        @(negedge clk);
        n++;
      end
      check("small_timeout", 32'(n < 200), 32'd1);
      check("small_head", 32'(sbus.plot_x == 2'd2 && sbus.plot_y == 2'd2), 32'd0);
      nplots = 0;
      sbus.head_x = sbus.plot_x;
      sbus.head_y = sbus.plot_y;
      sbus.head_valid = 1'b1;
      @(negedge clk);
      sbus.head_valid = 1'b0;
      sbus.head_x = 2'd2;
      sbus.head_y = 2'd2;
      while (!sbus.plot_req && nplots < 200) begin
        @(negedge clk);
        nplots++;
      end
      if (nplots >= 200) check("small_regen", 32'd0, 32'd1);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
